// File: rtl/mem_burst_reader.sv
// Burst reader for the ALU result memory: streams req_len+1 words to a valid/ready channel.
// Define MEM_RD_FWD_EN for write-first forwarding on a same-cycle write/read collision.
module mem_burst_reader #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8,
    parameter int unsigned RW = 4,
    parameter int unsigned LW = 4
) (
    input  logic          clk_1,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic [RW-1:0] req_r_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [RW-1:0] rsp_r_addr,
    output logic          rsp_last,
    output logic          busy
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic [RW-1:0] cur_r_q, cur_r_d;

    logic [DW-1:0] mem_q [Depth];

    logic [DW-1:0] buf_data_q [2];
    logic [RW-1:0] buf_r_q [2];
    logic          buf_last_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q;

    logic          issue, issue_last, pop;
    logic [DW-1:0] rd_word;

    always_ff @(posedge clk_1) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word = mem_q[cur_addr_q];
`ifdef MEM_RD_FWD_EN
        if (wr_en && (wr_addr == cur_addr_q)) begin
            rd_word = wr_data;
        end
`endif
    end

    // Issue gating on buffer occupancy keeps the 2-entry buffer from overflowing.
    assign issue      = (state_q == StIssue) && (count_q < 2'd2);
    assign issue_last = issue && (remaining_q == '0);
    assign rsp_valid  = (count_q != 2'd0);
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_data   = rsp_valid ? buf_data_q[rd_ptr_q] : '0;
    assign rsp_r_addr = rsp_valid ? buf_r_q[rd_ptr_q] : '0;
    assign rsp_last   = rsp_valid && buf_last_q[rd_ptr_q];
    assign req_ready  = (state_q == StIdle) && !rst;
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        cur_r_d     = cur_r_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cur_addr_d  = req_addr;
                    remaining_d = req_len;
                    cur_r_d     = req_r_addr;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    cur_r_d     = cur_r_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && rsp_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            cur_r_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            cur_r_q     <= cur_r_d;
        end
    end

    // The issued read lands directly in the output buffer one edge later.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_r_q[i]    <= '0;
                buf_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (issue) begin
                buf_data_q[wr_ptr_q] <= rd_word;
                buf_r_q[wr_ptr_q]    <= cur_r_q;
                buf_last_q[wr_ptr_q] <= issue_last;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, issue} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed self-checking bench for mem_burst_reader.
module tb_mem_burst_reader;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [3:0]  req_r_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_r_addr;
    logic        rsp_last;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [15:0] mdl [256];

    mem_burst_reader dut (
        .clk_1      (clk_1),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_r_addr (req_r_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_r_addr (rsp_r_addr),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    always #5 clk_1 = ~clk_1;

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        mdl[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Issues one request and checks every beat against the bench memory model.
    task automatic run_burst(input logic [7:0] a, input logic [3:0] l, input logic [3:0] r,
                             input bit bp);
        int beat = 0;
        bit done = 1'b0;
        bit stall = 1'b0;
        logic [15:0] pd = '0;
        logic [3:0] pr = '0;
        logic pl = 1'b0;
        logic [7:0] ia;
        for (int w = 0; w < 50 && !req_ready; w++) tick();
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr = a;
        req_len = l;
        req_r_addr = r;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            rsp_ready = bp ? (c % 3 == 0) : 1'b1;
            if (stall) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_data", 32'(rsp_data), 32'(pd));
                chk("stall_r_addr", 32'(rsp_r_addr), 32'(pr));
                chk("stall_last", 32'(rsp_last), 32'(pl));
            end
            if (rsp_valid && rsp_ready) begin
                ia = a + 8'(beat);
                chk("beat_data", 32'(rsp_data), 32'(mdl[ia]));
                chk("beat_r_addr", 32'(rsp_r_addr), 32'(4'(r + 4'(beat))));
                chk("beat_last", 32'(rsp_last), 32'(beat == int'(l)));
                if (rsp_last) done = 1'b1;
                beat++;
                stall = 1'b0;
            end else begin
                stall = rsp_valid;
                pd = rsp_data;
                pr = rsp_r_addr;
                pl = rsp_last;
            end
            tick();
        end
        rsp_ready = 1'b1;
        chk("beat_count", 32'(beat), 32'(int'(l) + 1));
        chk("busy_after_burst", 32'(busy), 32'd0);
        chk("req_ready_after_burst", 32'(req_ready), 32'd1);
        chk("no_extra_beat", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] e1 [4];
        e1[0] = 16'h1111;
        e1[1] = 16'h2222;
        e1[2] = 16'h3333;
        e1[3] = 16'h4444;

        // Reset state
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        tick();

        for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i), e1[i]);
        write_word(8'hFE, 16'hAAAA);
        write_word(8'hFF, 16'hBBBB);
        write_word(8'h00, 16'hCCCC);
        for (int i = 0; i < 8; i++) write_word(8'h40 + 8'(i), 16'h7000 + 16'(i * 16'h0111));
        write_word(8'h20, 16'h1234);

        // Basic burst with fixed latency: accept T, issue T+1, first beat T+2
        rsp_ready = 1'b1;
        chk("b1_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr = 8'h10;
        req_len = 4'd3;
        req_r_addr = 4'd2;
        tick();
        req_valid = 1'b0;
        chk("b1_busy_t1", 32'(busy), 32'd1);
        chk("b1_req_ready_t1", 32'(req_ready), 32'd0);
        chk("b1_valid_t1", 32'(rsp_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("b1_valid", 32'(rsp_valid), 32'd1);
            chk("b1_data", 32'(rsp_data), 32'(e1[i]));
            chk("b1_r_addr", 32'(rsp_r_addr), 32'(2 + i));
            chk("b1_last", 32'(rsp_last), 32'(i == 3));
            chk("b1_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("b1_busy_end", 32'(busy), 32'd0);
        chk("b1_req_ready_end", 32'(req_ready), 32'd1);
        chk("b1_valid_end", 32'(rsp_valid), 32'd0);

        // Address and register-address wrap
        run_burst(8'hFE, 4'd2, 4'd15, 1'b0);

        // Backpressure with rsp_ready pattern 1,0,0 repeating
        run_burst(8'h40, 4'd7, 4'd4, 1'b1);

        // Same-cycle write/read collision on 0x20
        req_valid = 1'b1;
        req_addr = 8'h20;
        req_len = 4'd0;
        req_r_addr = 4'd6;
        tick();
        req_valid = 1'b0;
        wr_en = 1'b1;
        wr_addr = 8'h20;
        wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0;
        chk("col_valid", 32'(rsp_valid), 32'd1);
`ifdef MEM_RD_FWD_EN
        chk("col_data", 32'(rsp_data), 32'h5A5A);
`else
        chk("col_data", 32'(rsp_data), 32'h1234);
`endif
        chk("col_last", 32'(rsp_last), 32'd1);
        tick();
        chk("col_busy_end", 32'(busy), 32'd0);
        mdl[8'h20] = 16'h5A5A;
        run_burst(8'h20, 4'd0, 4'd3, 1'b0);

        // Reset in the middle of an 8-beat burst
        req_valid = 1'b1;
        req_addr = 8'h40;
        req_len = 4'd7;
        req_r_addr = 4'd0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_beat0", 32'(rsp_data), 32'(mdl[8'h40]));
        tick();
        chk("mid_beat1", 32'(rsp_data), 32'(mdl[8'h41]));
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_burst(8'h10, 4'd0, 4'd7, 1'b0);

        // Second request while busy is ignored
        req_valid = 1'b1;
        req_addr = 8'h10;
        req_len = 4'd3;
        req_r_addr = 4'd0;
        tick();
        req_addr = 8'hFE;
        req_len = 4'd0;
        req_r_addr = 4'd9;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_b_valid", 32'(rsp_valid), 32'd1);
            chk("busy_b_data", 32'(rsp_data), 32'(e1[i]));
            chk("busy_b_r_addr", 32'(rsp_r_addr), 32'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("busy_ignored_valid", 32'(rsp_valid), 32'd0);
            chk("busy_ignored_busy", 32'(busy), 32'd0);
            tick();
        end
        run_burst(8'hFE, 4'd0, 4'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side counterpart of the pipelined ALU's result memory.
- Owns a 256x16 result memory. Stage 4 of the ALU pipeline writes it through a simple write port.
- A requester issues burst read requests (base address, length, destination register).
- The block streams the words back over a valid/ready response channel, each tagged with an incrementing register address, for reload into the register bank.

Parameters:
- DW, 16, data width of memory words and rsp_data.
- AW, 8, memory address width; depth = 2**AW.
- RW, 4, register-address width; register addresses wrap modulo 2**RW.
- LW, 4, burst-length field width; burst = req_len+1 words (1..16).

Ports:
- clk_1  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  memory write strobe.
- wr_addr  in  AW  memory write address.
- wr_data  in  DW  memory write data.
- req_valid  in  1  burst request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  AW  burst base address.
- req_len  in  LW  burst length minus one.
- req_r_addr  in  RW  destination register address of first beat.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  downstream accepts beat.
- rsp_data  out  DW  memory word.
- rsp_r_addr  out  RW  destination register for this beat.
- rsp_last  out  1  high on final beat of burst.
- busy  out  1  high from request accept until last beat handed off.

Behaviour:
- Reset (async, immediate):
  - FSM to IDLE.
  - Counters and read pipeline cleared; in-flight reads dropped.
  - Output buffer emptied.
  - rsp_valid=0, rsp_data=0, rsp_r_addr=0, rsp_last=0, busy=0, req_ready=0 while rst high.
  - Memory contents are not reset.
- Memory: synchronous write when wr_en. Synchronous read with 1-cycle latency (address registered at cycle N, data in buffer at N+1).
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch cur_addr=req_addr, remaining=req_len, cur_r=req_r_addr; go ISSUE.
  - ISSUE: req_ready=0. Issue one read per cycle while (buffer_count + inflight) < 2. Each issue increments cur_addr (wraps 255->0) and cur_r (wraps 15->0) and decrements remaining. Issuing the read with remaining==0 tags it last and moves to DRAIN.
  - DRAIN: no issues. Return to IDLE in the cycle the last-tagged beat is accepted (rsp_valid&rsp_ready&rsp_last).
- Output buffer:
  - 2-entry FIFO holding {data, r_addr, last}. Head drives rsp_*.
  - rsp_valid = not empty.
  - Beat leaves on rsp_valid&rsp_ready. Push and pop in the same cycle are both performed.
  - Never overflows: issue gating counts in-flight reads.
  - Throughput: 1 beat/cycle with rsp_ready held high.
- Latency: request accept at cycle T -> first read issued T+1 -> rsp_valid high at T+2.
- Backpressure: rsp_ready low holds rsp_* stable; issue stalls once 2 entries are occupied or reserved.
- busy = (state != IDLE).
- Read/write collision:
  - Write to an address not yet read in the burst: later reads see the new data.
  - Same-cycle write and read of the same address: see Optional Feature.
- Burst crossing address 255: continues at 0; no error.
- req_valid while busy: ignored (req_ready=0); the requester must hold it.

Optional Feature:
- Macro MEM_RD_FWD_EN.
- Defined: same-cycle wr_en with wr_addr == issued read address returns wr_data (write-first forwarding).
- Undefined: the read returns the pre-write contents (read-first). The write still lands.

Test Plan:
- Write mem[0x10..0x13]=0x1111,0x2222,0x3333,0x4444. Request addr=0x10, len=3, r_addr=2, rsp_ready=1 -> 4 consecutive beats from T+2: data 0x1111..0x4444, r_addr 2..5, rsp_last only on 0x4444. busy falls and req_ready rises after the last beat.
- Wrap: mem[0xFE]=0xAAAA, mem[0xFF]=0xBBBB, mem[0x00]=0xCCCC. Request addr=0xFE, len=2, r_addr=15 -> data AAAA, BBBB, CCCC; r_addr 15, 0, 1.
- Backpressure: len=7, toggle rsp_ready 1,0,0,1,... -> every beat delivered exactly once, in order, with rsp_* stable while stalled. At most 2 reads outstanding. 8 beats total.
- Collision: burst on 0x20 with wr_en to 0x20 (data 0x5A5A) in the issue cycle -> beat = 0x5A5A with MEM_RD_FWD_EN, old value without. mem[0x20]=0x5A5A afterwards in both builds.
- Reset mid-burst: assert rst after 2 of 8 beats -> rsp_valid=0, busy=0 immediately. After release, a new request len=0 returns exactly one beat with rsp_last=1.
- Request while busy: pulse req_valid with a second request during a burst -> ignored. Accepted only when re-presented after IDLE.
